uart_io_bridge: RTL and testbench
=================================

Name: uart_io_bridge

Overview:
- Port-mapped I/O bridge between the processor I/O bus (port ID, read/write strobes) and the rs232_uart instance.
- Buffers processor TX writes in a small FIFO and drains them into the UART whenever its TX buffer has room.
- Serves RX data and status reads, and holds an 8-bit PIO output register.
- Replaces the ad-hoc write/read decode in the top level; runs on the single processor/UART clock.

Parameters:
TX_FIFO_DEPTH  8      TX holding FIFO entries; power of 2, >= 2
TX_PTR_WID     3      log2(TX_FIFO_DEPTH)
PORT_UART      8'h01  UART data port (write = TX push, read = RX pop)
PORT_STATUS    8'h02  status port (read) / overflow clear (write)
PORT_PIO       8'h04  PIO output register (read/write)

Ports:
clk              in   1  single clock, rising edge
reset            in   1  synchronous, active-high
io_port_id       in   8  processor port ID
io_write_data    in   8  processor write data
io_write_strobe  in   1  one-cycle write strobe
io_read_strobe   in   1  one-cycle read strobe
io_read_data     out  8  registered read data to processor
uart_tx_data     out  8  byte to UART TX
uart_write       out  1  one-cycle UART TX write pulse
uart_tx_full     in   1  UART TX buffer full
uart_rx_data     in   8  UART RX head byte
uart_rx_present  in   1  UART RX data available
uart_rx_ack      out  1  one-cycle UART RX read ack
pio_out          out  8  PIO output register
tx_overflow      out  1  sticky TX FIFO overflow flag

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - TX FIFO is empty (pointers and count 0).
  - Drain FSM is in IDLE.
  - The reset edge overrides everything, including an in-flight send: uart_write is 0 after that edge.
- Write decode (io_write_strobe=1):
  - PORT_UART: push io_write_data into the TX FIFO.
  - PORT_STATUS: if io_write_data[3]=1, clear tx_overflow; other bits ignored.
  - PORT_PIO: pio_out <= io_write_data on the next edge.
  - Any other port: ignored, no side effects.
- Push/pop rules:
  - A push is accepted if count < TX_FIFO_DEPTH, or if a pop occurs in the same cycle (count unchanged).
  - A push to a full FIFO with no simultaneous pop drops the byte and sets tx_overflow.
  - If a set and a clear hit tx_overflow in the same cycle, set wins.
  - Pointers wrap modulo TX_FIFO_DEPTH; count width is TX_PTR_WID+1.
- Drain FSM:
  - IDLE: if FIFO not empty and uart_tx_full=0, then on the next edge:
    - uart_tx_data <= FIFO head;
    - uart_write <= 1;
    - pop the head;
    - go to HOLD.
  - HOLD: uart_write <= 0, go to IDLE. The extra cycle lets uart_tx_full update before the next send.
  - Maximum throughput is 1 byte per 2 cycles. uart_write is never high on two consecutive cycles.
  - uart_tx_data holds its last value between sends.
- Read decode (io_read_strobe=1): io_read_data updates on the next edge and holds until the next read strobe.
  - PORT_UART, uart_rx_present=1: return uart_rx_data and pulse uart_rx_ack for exactly one cycle, concurrent with the data update.
  - PORT_UART, uart_rx_present=0: return 8'h00, no ack.
  - PORT_STATUS: return {4'b0, tx_overflow, fifo_empty, fifo_full, uart_rx_present}, i.e. bit0 rx_present, bit1 fifo_full, bit2 fifo_empty, bit3 tx_overflow.
  - PORT_PIO: return pio_out.
  - Any other port: return 8'h00.
- Simultaneous read and write strobes: both are decoded independently in the same cycle.
- Read-status latency: status is sampled in the strobe cycle, so a same-cycle push is not yet reflected.

Test Plan:
- Reset, then PORT_STATUS read -> io_read_data=8'h04 (empty); pio_out=0, uart_write=0, tx_overflow=0.
- Write 8'hA5 then 8'h3C to port 0x01, uart_tx_full=0 -> uart_write pulses twice, 2 cycles apart, with uart_tx_data=A5 then 3C; FIFO empty afterwards.
- Hold uart_tx_full=1 and write 9 bytes 0x10..0x18 -> status reads 8'h0A (full, overflow). Release full -> exactly 0x10..0x17 sent in order. Write 8'h08 to port 0x02 -> tx_overflow=0.
- uart_rx_present=1, uart_rx_data=8'h5A, read port 0x01 -> io_read_data=5A with one uart_rx_ack pulse. Repeat with uart_rx_present=0 -> 8'h00, no ack.
- Write 8'hC3 to port 0x04, then read port 0x04 -> pio_out=C3, io_read_data=C3. Write to port 0x07 -> no state change.
- Assert reset during HOLD with 3 bytes queued -> after the reset edge uart_write=0, FIFO empty, and no further sends after reset is released.

Source files
------------

// File: rtl/uart_io_bridge.sv
// Port-mapped I/O bridge between the processor I/O bus and the rs232_uart:
// TX holding FIFO with a paced drain FSM, RX/status read decode, PIO output register.
module uart_io_bridge #(
  parameter int         TX_FIFO_DEPTH = 8,
  parameter int         TX_PTR_WID    = 3,
  parameter logic [7:0] PORT_UART     = 8'h01,
  parameter logic [7:0] PORT_STATUS   = 8'h02,
  parameter logic [7:0] PORT_PIO      = 8'h04
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] io_port_id,
  input  logic [7:0] io_write_data,
  input  logic       io_write_strobe,
  input  logic       io_read_strobe,
  output logic [7:0] io_read_data,
  output logic [7:0] uart_tx_data,
  output logic       uart_write,
  input  logic       uart_tx_full,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_present,
  output logic       uart_rx_ack,
  output logic [7:0] pio_out,
  output logic       tx_overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } drain_state_t;

  localparam logic [TX_PTR_WID:0] FIFO_FULL_CNT = (TX_PTR_WID + 1)'(TX_FIFO_DEPTH);

  drain_state_t state, next_state;

  logic [7:0]          fifo_mem [TX_FIFO_DEPTH];
  logic [TX_PTR_WID-1:0] wr_ptr, rd_ptr;
  logic [TX_PTR_WID:0]   count;

  logic fifo_empty, fifo_full;
  logic push_req, push_ok, pop;
  logic ovf_set, ovf_clr;
  logic [7:0] status_byte;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_FULL_CNT);

  assign push_req = io_write_strobe && (io_port_id == PORT_UART);
  // A full FIFO still accepts a push when the drain pops in the same cycle.
  assign push_ok  = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;
  assign ovf_clr  = io_write_strobe && (io_port_id == PORT_STATUS) && io_write_data[3];

  assign status_byte = {4'b0000, tx_overflow, fifo_empty, fifo_full, uart_rx_present};

  // Drain FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Drain FSM: next state and pop decision
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !uart_tx_full) begin
          pop        = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the FIFO storage has no reset; pointers and count define validity, and a
  // reset-free array maps onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= io_write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)        tx_overflow <= 1'b0;
    else if (ovf_set) tx_overflow <= 1'b1;
    else if (ovf_clr) tx_overflow <= 1'b0;
  end

  // uart_write only rises from IDLE, and HOLD always follows, so pulses never abut.
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_write   <= 1'b0;
      uart_tx_data <= 8'h00;
    end else begin
      uart_write <= pop;
      if (pop) uart_tx_data <= fifo_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pio_out <= 8'h00;
    end else if (io_write_strobe && (io_port_id == PORT_PIO)) begin
      pio_out <= io_write_data;
    end
  end

  // Read data holds between strobes; the RX ack is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_read_data <= 8'h00;
      uart_rx_ack  <= 1'b0;
    end else begin
      uart_rx_ack <= 1'b0;
      if (io_read_strobe) begin
        case (io_port_id)
          PORT_UART: begin
            if (uart_rx_present) begin
              io_read_data <= uart_rx_data;
              uart_rx_ack  <= 1'b1;
            end else begin
              io_read_data <= 8'h00;
            end
          end
          PORT_STATUS: io_read_data <= status_byte;
          PORT_PIO:    io_read_data <= pio_out;
          default:     io_read_data <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed self-checking bench for uart_io_bridge with hand-computed expectations.
module tb_uart_io_bridge;

  logic       clk;
  logic       reset;
  logic [7:0] io_port_id;
  logic [7:0] io_write_data;
  logic       io_write_strobe;
  logic       io_read_strobe;
  logic [7:0] io_read_data;
  logic [7:0] uart_tx_data;
  logic       uart_write;
  logic       uart_tx_full;
  logic [7:0] uart_rx_data;
  logic       uart_rx_present;
  logic       uart_rx_ack;
  logic [7:0] pio_out;
  logic       tx_overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] sent_q[$];
  int         sent_cyc[$];
  int         cyc = 0;
  int         ack_cnt = 0;
  logic       prev_write = 1'b0;
  int         ack_before;

  uart_io_bridge dut (
    .clk             (clk),
    .reset           (reset),
    .io_port_id      (io_port_id),
    .io_write_data   (io_write_data),
    .io_write_strobe (io_write_strobe),
    .io_read_strobe  (io_read_strobe),
    .io_read_data    (io_read_data),
    .uart_tx_data    (uart_tx_data),
    .uart_write      (uart_write),
    .uart_tx_full    (uart_tx_full),
    .uart_rx_data    (uart_rx_data),
    .uart_rx_present (uart_rx_present),
    .uart_rx_ack     (uart_rx_ack),
    .pio_out         (pio_out),
    .tx_overflow     (tx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // UART-side monitor: records every send and flags back-to-back write pulses.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (uart_write) begin
      check("uart_write_gap", {31'b0, prev_write}, 32'd0);
      sent_q.push_back(uart_tx_data);
      sent_cyc.push_back(cyc);
    end
    if (uart_rx_ack) ack_cnt++;
    prev_write = uart_write;
  end

  // Bus helpers: called at a falling edge, return at the falling edge after the strobe edge.
  task automatic bus_write(input logic [7:0] port, input logic [7:0] data);
    io_port_id      = port;
    io_write_data   = data;
    io_write_strobe = 1'b1;
    @(negedge clk);
    io_write_strobe = 1'b0;
    io_port_id      = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] port);
    io_port_id     = port;
    io_read_strobe = 1'b1;
    @(negedge clk);
    io_read_strobe = 1'b0;
    io_port_id     = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    io_port_id      = 8'h00;
    io_write_data   = 8'h00;
    io_write_strobe = 1'b0;
    io_read_strobe  = 1'b0;
    uart_tx_full    = 1'b0;
    uart_rx_data    = 8'h00;
    uart_rx_present = 1'b0;

    // Reset state
    idle(3);
    check("rst_uart_write", {31'b0, uart_write}, 32'd0);
    check("rst_pio_out", {24'b0, pio_out}, 32'h00);
    check("rst_tx_overflow", {31'b0, tx_overflow}, 32'd0);
    check("rst_read_data", {24'b0, io_read_data}, 32'h00);
    check("rst_rx_ack", {31'b0, uart_rx_ack}, 32'd0);
    reset = 1'b0;
    idle(1);
    bus_read(8'h02);
    check("rst_status", {24'b0, io_read_data}, 32'h04);

    // Two bytes drained at one byte per two cycles
    sent_q.delete();
    sent_cyc.delete();
    bus_write(8'h01, 8'hA5);
    bus_write(8'h01, 8'h3C);
    idle(8);
    check("tx2_count", sent_q.size(), 32'd2);
    if (sent_q.size() == 2) begin
      check("tx2_byte0", {24'b0, sent_q[0]}, 32'hA5);
      check("tx2_byte1", {24'b0, sent_q[1]}, 32'h3C);
      check("tx2_spacing", sent_cyc[1] - sent_cyc[0], 32'd2);
    end
    bus_read(8'h02);
    check("tx2_status_empty", {24'b0, io_read_data}, 32'h04);

    // Fill while the UART is full, overflow on the ninth byte
    sent_q.delete();
    uart_tx_full = 1'b1;
    for (int i = 0; i < 9; i++) bus_write(8'h01, 8'h10 + 8'(i));
    check("full_no_send", sent_q.size(), 32'd0);
    check("full_overflow", {31'b0, tx_overflow}, 32'd1);
    bus_read(8'h02);
    check("full_status", {24'b0, io_read_data}, 32'h0A);
    bus_write(8'h02, 8'hF7);
    check("ovf_no_clear_bit3_0", {31'b0, tx_overflow}, 32'd1);
    uart_tx_full = 1'b0;
    idle(24);
    check("drain_count", sent_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < sent_q.size()) check($sformatf("drain_byte%0d", i), {24'b0, sent_q[i]}, 32'h10 + i);
    end
    bus_read(8'h02);
    check("drain_status", {24'b0, io_read_data}, 32'h0C);
    bus_write(8'h02, 8'h08);
    check("ovf_cleared", {31'b0, tx_overflow}, 32'd0);
    bus_read(8'h02);
    check("clear_status", {24'b0, io_read_data}, 32'h04);

    // RX pop with and without data present
    uart_rx_present = 1'b1;
    uart_rx_data    = 8'h5A;
    ack_before      = ack_cnt;
    bus_read(8'h01);
    check("rx_data", {24'b0, io_read_data}, 32'h5A);
    check("rx_ack_now", {31'b0, uart_rx_ack}, 32'd1);
    idle(2);
    check("rx_ack_pulses", ack_cnt - ack_before, 32'd1);
    bus_read(8'h02);
    check("rx_status", {24'b0, io_read_data}, 32'h05);
    uart_rx_present = 1'b0;
    ack_before      = ack_cnt;
    bus_read(8'h01);
    check("rx_empty_data", {24'b0, io_read_data}, 32'h00);
    idle(3);
    check("rx_empty_no_ack", ack_cnt - ack_before, 32'd0);

    // PIO register and unmapped port
    bus_write(8'h04, 8'hC3);
    check("pio_write", {24'b0, pio_out}, 32'hC3);
    bus_read(8'h04);
    check("pio_read", {24'b0, io_read_data}, 32'hC3);
    sent_q.delete();
    bus_write(8'h07, 8'hFF);
    idle(4);
    check("unmapped_pio", {24'b0, pio_out}, 32'hC3);
    check("unmapped_ovf", {31'b0, tx_overflow}, 32'd0);
    check("unmapped_no_send", sent_q.size(), 32'd0);
    bus_read(8'h07);
    check("unmapped_read", {24'b0, io_read_data}, 32'h00);

    // Simultaneous read and write of the PIO port: the read sees the old value
    io_port_id      = 8'h04;
    io_write_data   = 8'h5E;
    io_write_strobe = 1'b1;
    io_read_strobe  = 1'b1;
    @(negedge clk);
    io_write_strobe = 1'b0;
    io_read_strobe  = 1'b0;
    io_port_id      = 8'h00;
    check("rw_same_read", {24'b0, io_read_data}, 32'hC3);
    check("rw_same_pio", {24'b0, pio_out}, 32'h5E);

    // Reset during HOLD with three bytes still queued
    sent_q.delete();
    uart_tx_full = 1'b1;
    for (int i = 0; i < 4; i++) bus_write(8'h01, 8'h21 + 8'(i));
    uart_tx_full = 1'b0;
    @(negedge clk);
    check("hold_uart_write", {31'b0, uart_write}, 32'd1);
    check("hold_tx_data", {24'b0, uart_tx_data}, 32'h21);
    reset = 1'b1;
    @(negedge clk);
    check("rst_hold_uart_write", {31'b0, uart_write}, 32'd0);
    check("rst_hold_pio", {24'b0, pio_out}, 32'h00);
    reset = 1'b0;
    idle(20);
    check("rst_hold_sends", sent_q.size(), 32'd1);
    bus_read(8'h02);
    check("rst_hold_status", {24'b0, io_read_data}, 32'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
